// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences the shared PC/IR/A/B/ALUOut/MDR datapath
// through fetch, decode, execute, memory and write-back, stalling on mem_ready.
module mc_ctrl_fsm #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            overflow,
  input  logic            mem_ready,
  output logic            mem_rd,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic [1:0]      PCSource,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic [1:0]      ExtOp,
  output logic            RegWrite,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic            write_gpr30,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWR  = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JR     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  state_t r_state;
  state_t w_next;
  logic   r_ovf_q;

  logic       w_mem_rd, w_mem_write, w_ir_write, w_pc_write;
  logic [1:0] w_pc_source;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_op;
  logic [1:0] w_ext_op;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_write_gpr30;
  logic       w_illegal;

  // State register and addi overflow latch (captured in EXE_I, consumed in WB_ALU)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ovf_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXE_I) begin
        r_ovf_q <= overflow & (opcode == OP_ADDI);
      end else if (r_state == S_WB_ALU) begin
        r_ovf_q <= 1'b0;
      end else begin
        r_ovf_q <= r_ovf_q;
      end
    end
  end

  // Next-state and per-state datapath control decode
  always_comb begin
    w_next        = r_state;
    w_mem_rd      = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_source   = 2'b00;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_op      = 3'b000;
    w_ext_op      = 2'b00;
    w_reg_write   = 1'b0;
    w_reg_dst     = 2'b00;
    w_mem_to_reg  = 2'b00;
    w_write_gpr30 = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_rd    = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_ext_op    = 2'b01;
        case (opcode)
          OP_R: begin
            case (funct)
              FN_ADDU, FN_SUBU, FN_SLT, FN_SLL: w_next = S_EXE_R;
              FN_JR:                            w_next = S_JR;
              default: begin
                w_illegal = 1'b1;
                w_next    = S_FETCH;
              end
            endcase
          end
          OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: w_next = S_EXE_I;
          OP_LW, OP_SW:                      w_next = S_MEMADR;
          OP_BEQ:                            w_next = S_BRANCH;
          OP_J, OP_JAL:                      w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_EXE_R: begin
        w_alu_src_a = 1'b1;
        case (funct)
          FN_SUBU: w_alu_op = 3'b001;
          FN_SLT:  w_alu_op = 3'b011;
          FN_SLL:  w_alu_op = 3'b101;
          default: w_alu_op = 3'b000;
        endcase
        w_next = S_WB_ALU;
      end
      S_EXE_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        case (opcode)
          OP_ORI: begin
            w_alu_op = 3'b010;
            w_ext_op = 2'b00;
          end
          OP_LUI: begin
            w_alu_op = 3'b000;
            w_ext_op = 2'b10;
          end
          OP_ADDI: begin
            w_alu_op = 3'b100;
            w_ext_op = 2'b01;
          end
          default: begin
            w_alu_op = 3'b000;
            w_ext_op = 2'b01;
          end
        endcase
        w_next = S_WB_ALU;
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_ext_op    = 2'b01;
        if (opcode == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMRD: begin
        w_mem_rd = 1'b1;
        if (mem_ready) begin
          w_next = S_WB_MEM;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
        // On addi overflow the datapath writes 1 to $30 and rt stays untouched
        if (r_ovf_q) begin
          w_write_gpr30 = 1'b1;
          w_reg_dst     = 2'b00;
        end else if (opcode == OP_R) begin
          w_reg_dst = 2'b01;
        end else begin
          w_reg_dst = 2'b00;
        end
        w_next = S_FETCH;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b01;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 3'b001;
        w_pc_source = 2'b01;
        w_pc_write  = zero;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
        if (opcode == OP_JAL) begin
          w_reg_write  = 1'b1;
          w_reg_dst    = 2'b10;
          w_mem_to_reg = 2'b10;
        end else begin
          w_reg_write = 1'b0;
        end
        w_next = S_FETCH;
      end
      S_JR: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b11;
        w_next      = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Every output is forced low while reset is asserted, without waiting for a clock
  assign mem_rd      = w_mem_rd & rst_n;
  assign MemWrite    = w_mem_write & rst_n;
  assign IRWrite     = w_ir_write & rst_n;
  assign PCWrite     = w_pc_write & rst_n;
  assign PCSource    = w_pc_source & {2{rst_n}};
  assign ALUSrcA     = w_alu_src_a & rst_n;
  assign ALUSrcB     = w_alu_src_b & {2{rst_n}};
  assign ALUOp       = w_alu_op & {3{rst_n}};
  assign ExtOp       = w_ext_op & {2{rst_n}};
  assign RegWrite    = w_reg_write & rst_n;
  assign RegDst      = w_reg_dst & {2{rst_n}};
  assign MemtoReg    = w_mem_to_reg & {2{rst_n}};
  assign write_gpr30 = w_write_gpr30 & rst_n;
  assign illegal     = w_illegal & rst_n;
  assign state       = rst_n ? ST_W'(r_state) : {ST_W{1'b0}};

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes the hand-computed control vector
// for each cycle, a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef struct packed {
    logic [3:0] st;
    logic       mrd, mw, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] ext;
    logic       rw;
    logic [1:0] rd, m2r;
    logic       g30, ill;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, overflow, mem_ready;
  logic       mem_rd, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite, write_gpr30, illegal;
  logic [1:0] PCSource, ALUSrcB, ExtOp, RegDst, MemtoReg;
  logic [2:0] ALUOp;
  logic [3:0] state;

  item_t q[$];
  int    n_vec = 0;
  int    n_err = 0;

  mc_ctrl_fsm #(.ST_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .mem_rd(mem_rd), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .write_gpr30(write_gpr30),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t ev(input logic [3:0] st, input logic mrd, mw, irw, pcw,
                              input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
                              input logic [2:0] aop, input logic [1:0] ext, input logic rw,
                              input logic [1:0] rd, m2r, input logic g30, ill);
    vec_t v;
    v = '{st, mrd, mw, irw, pcw, pcs, asa, asb, aop, ext, rw, rd, m2r, g30, ill};
    return v;
  endfunction

  // Hand-written expected vectors for each state
  function automatic vec_t e_zero();
    return ev(4'd0, 1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_fetch(input logic rdy);
    return ev(4'd0, 1'b1,1'b0,rdy,rdy, 2'b00, 1'b0, 2'b01, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_dec(input logic ill);
    return ev(4'd1, 1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b11, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, ill);
  endfunction
  function automatic vec_t e_exr(input logic [2:0] aop);
    return ev(4'd2, 1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1, 2'b00, aop, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_exi(input logic [2:0] aop, input logic [1:0] ext);
    return ev(4'd3, 1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1, 2'b10, aop, ext, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_madr();
    return ev(4'd4, 1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_mrd();
    return ev(4'd5, 1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_mwr();
    return ev(4'd6, 1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_wba(input logic [1:0] rd, input logic g30);
    return ev(4'd7, 1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1, rd, 2'b00, g30, 1'b0);
  endfunction
  function automatic vec_t e_wbm();
    return ev(4'd8, 1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_br(input logic z);
    return ev(4'd9, 1'b0,1'b0,1'b0,z, 2'b01, 1'b1, 2'b00, 3'b001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_jmp(input logic jal);
    return ev(4'd10, 1'b0,1'b0,1'b0,1'b1, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00, jal,
              jal ? 2'b10 : 2'b00, jal ? 2'b10 : 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic vec_t e_jr();
    return ev(4'd11, 1'b0,1'b0,1'b0,1'b1, 2'b11, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction

  // One clock of stimulus: drive inputs just after the edge and queue the expected vector
  task automatic cyc(input logic rst, input logic [5:0] op, fn, input logic z, ov, rdy,
                     input vec_t e, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    rst_n = rst; opcode = op; funct = fn; zero = z; overflow = ov; mem_ready = rdy;
    it.v = e;
    it.tag = tag;
    q.push_back(it);
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge
  always @(negedge clk) begin
    vec_t  act;
    item_t it;
    if (q.size() > 0) begin
      it  = q.pop_front();
      act = '{state, mem_rd, MemWrite, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp,
              ExtOp, RegWrite, RegDst, MemtoReg, write_gpr30, illegal};
      n_vec++;
      if (act !== it.v) begin
        n_err++;
        $display("FAIL %s: got %h expected %h (state %0d)", it.tag, act, it.v, state);
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
    cyc(1'b0, OP_R, FN_ADDU, 1'b0, 1'b0, 1'b1, e_zero(), "reset_hold0");
    cyc(1'b0, OP_R, FN_ADDU, 1'b0, 1'b0, 1'b1, e_zero(), "reset_hold1");

    // T1: sw stalled in MEMWR, then asynchronous reset
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "t1_fetch");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "t1_dec");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_madr(), "t1_madr");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, e_mwr(), "t1_mwr");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (MemWrite !== 1'b0 || state !== 4'd0 || mem_rd !== 1'b0) begin
      n_err++;
      $display("FAIL t1_async: MemWrite=%b state=%0d mem_rd=%b expected 0/0/0", MemWrite, state, mem_rd);
    end
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_zero(), "t1_in_reset");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), "t1_release_stall");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "t1_release");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "t1_dec2");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_madr(), "t1_madr2");
    cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_mwr(), "t1_mwr_accept");

    // T2: addu 0,1,2,7
    cyc(1'b1, OP_R, FN_ADDU, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "t2_fetch");
    cyc(1'b1, OP_R, FN_ADDU, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "t2_dec");
    cyc(1'b1, OP_R, FN_ADDU, 1'b0, 1'b0, 1'b1, e_exr(3'b000), "t2_exr");
    cyc(1'b1, OP_R, FN_ADDU, 1'b0, 1'b0, 1'b1, e_wba(2'b01, 1'b0), "t2_wb");

    // T3: lw with two wait cycles in MEMRD
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "t3_fetch");
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "t3_dec");
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_madr(), "t3_madr");
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, e_mrd(), "t3_mrd_w0");
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, e_mrd(), "t3_mrd_w1");
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_mrd(), "t3_mrd_acc");
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_wbm(), "t3_wbm");

    // T4: beq taken then not taken
    for (int i = 0; i < 2; i++) begin
      logic z;
      z = (i == 0);
      cyc(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "t4_fetch");
      cyc(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "t4_dec");
      cyc(1'b1, OP_BEQ, 6'd0, z, 1'b0, 1'b1, e_br(z), "t4_branch");
    end

    // T5: addi with and without overflow, then addiu with overflow (ignored)
    for (int i = 0; i < 3; i++) begin
      logic [5:0] op;
      logic       ov, g;
      op = (i == 2) ? OP_ADDIU : OP_ADDI;
      ov = (i != 1);
      g  = (i == 0);
      cyc(1'b1, op, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "t5_fetch");
      cyc(1'b1, op, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "t5_dec");
      cyc(1'b1, op, 6'd0, 1'b0, ov, 1'b1, e_exi((i == 2) ? 3'b000 : 3'b100, 2'b01), "t5_exi");
      cyc(1'b1, op, 6'd0, 1'b0, 1'b0, 1'b1, e_wba(2'b00, g), "t5_wb");
    end

    // T6: jal, j, jr, illegal opcode and illegal funct
    cyc(1'b1, OP_JAL, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "t6_fetch");
    cyc(1'b1, OP_JAL, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "t6_dec");
    cyc(1'b1, OP_JAL, 6'd0, 1'b0, 1'b0, 1'b1, e_jmp(1'b1), "t6_jal");
    cyc(1'b1, OP_J, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "j_fetch");
    cyc(1'b1, OP_J, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "j_dec");
    cyc(1'b1, OP_J, 6'd0, 1'b0, 1'b0, 1'b1, e_jmp(1'b0), "j_jump");
    cyc(1'b1, OP_R, FN_JR, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "jr_fetch");
    cyc(1'b1, OP_R, FN_JR, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "jr_dec");
    cyc(1'b1, OP_R, FN_JR, 1'b0, 1'b0, 1'b1, e_jr(), "jr_jr");
    cyc(1'b1, OP_BAD, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "ill_fetch");
    cyc(1'b1, OP_BAD, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b1), "ill_dec");
    cyc(1'b1, OP_R, 6'b111111, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "illfn_fetch");
    cyc(1'b1, OP_R, 6'b111111, 1'b0, 1'b0, 1'b1, e_dec(1'b1), "illfn_dec");

    // Remaining ALU encodings: subu, slt, sll, ori, lui
    cyc(1'b1, OP_R, FN_SUBU, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "subu_fetch");
    cyc(1'b1, OP_R, FN_SUBU, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "subu_dec");
    cyc(1'b1, OP_R, FN_SUBU, 1'b0, 1'b0, 1'b1, e_exr(3'b001), "subu_exr");
    cyc(1'b1, OP_R, FN_SLT, 1'b0, 1'b0, 1'b1, e_wba(2'b01, 1'b0), "subu_wb");
    cyc(1'b1, OP_R, FN_SLT, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "slt_fetch");
    cyc(1'b1, OP_R, FN_SLT, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "slt_dec");
    cyc(1'b1, OP_R, FN_SLT, 1'b0, 1'b0, 1'b1, e_exr(3'b011), "slt_exr");
    cyc(1'b1, OP_R, FN_SLL, 1'b0, 1'b0, 1'b1, e_wba(2'b01, 1'b0), "slt_wb");
    cyc(1'b1, OP_R, FN_SLL, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "sll_fetch");
    cyc(1'b1, OP_R, FN_SLL, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "sll_dec");
    cyc(1'b1, OP_R, FN_SLL, 1'b0, 1'b0, 1'b1, e_exr(3'b101), "sll_exr");
    cyc(1'b1, OP_ORI, 6'd0, 1'b0, 1'b0, 1'b1, e_wba(2'b00, 1'b0), "sll_wb_nextop");
    cyc(1'b1, OP_ORI, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "ori_fetch");
    cyc(1'b1, OP_ORI, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "ori_dec");
    cyc(1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, 1'b1, e_exi(3'b010, 2'b00), "ori_exi");
    cyc(1'b1, OP_ORI, 6'd0, 1'b0, 1'b0, 1'b1, e_wba(2'b00, 1'b0), "ori_wb");
    cyc(1'b1, OP_LUI, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "lui_fetch");
    cyc(1'b1, OP_LUI, 6'd0, 1'b0, 1'b0, 1'b1, e_dec(1'b0), "lui_dec");
    cyc(1'b1, OP_LUI, 6'd0, 1'b0, 1'b0, 1'b1, e_exi(3'b000, 2'b10), "lui_exi");
    cyc(1'b1, OP_LUI, 6'd0, 1'b0, 1'b0, 1'b1, e_wba(2'b00, 1'b0), "lui_wb");
    cyc(1'b1, OP_LUI, 6'd0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), "end_fetch_stall");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
